// File: rtl/mem_pkg.sv
// Shared definitions for the memory request path: FSM state encodings,
// default timing parameters and the requester port-select encoding.
package mem_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  localparam int DEFAULT_TIMEOUT_CYCLES = 255;
  localparam int DEFAULT_GAP_CYCLES     = 2;

  typedef enum logic {
    PORT_FETCH = 1'b0,
    PORT_DATA  = 1'b1
  } port_sel_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter: on a tie the port not granted last wins.
// last_grant only advances when the grant is actually taken.
import mem_pkg::*;

module rr_arbiter2 (
  input  logic      clk,
  input  logic      reset,
  input  logic      req_fetch,
  input  logic      req_data,
  input  logic      accept,
  output logic      grant_valid,
  output port_sel_t grant
);

  port_sel_t last_grant;

  // NOTE: combinational blocks assign a default first so no path leaves grant unassigned (no latch).
  always_comb begin
    grant = PORT_FETCH;
    if (req_fetch && req_data) begin
      grant = (last_grant == PORT_FETCH) ? PORT_DATA : PORT_FETCH;
    end else if (req_data) begin
      grant = PORT_DATA;
    end
  end

  assign grant_valid = req_fetch | req_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= PORT_FETCH;
    end else if (accept && grant_valid) begin
      last_grant <= grant;
    end
  end

endmodule

// File: rtl/mem_request_arbiter.sv
// Arbitrates a fetch port and a data port onto one memory request channel,
// with a per-transaction timeout and an enforced idle gap after each completion.
import mem_pkg::*;

module mem_request_arbiter #(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int GAP_CYCLES     = DEFAULT_GAP_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_valid,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_valid,
  output logic        request,
  output logic        request_type,
  output logic [15:0] request_address,
  output logic [15:0] data_out,
  input  logic [15:0] data_in,
  input  logic        memory_ready,
  input  logic        write_complete,
  output logic        timeout_err,
  output logic        busy
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);

  logic [1:0] state;
  logic [7:0] wait_cnt;
  logic [7:0] gap_cnt;
  port_sel_t  granted;
  port_sel_t  grant;
  logic       grant_valid;

  logic        read_done;
  logic        write_done;
  logic        timed_out;
  logic        rdata_load;
  logic [15:0] rdata_next;

  rr_arbiter2 u_arb (
    .clk        (clk),
    .reset      (reset),
    .req_fetch  (if_req),
    .req_data   (d_req),
    .accept     (state == ST_IDLE),
    .grant_valid(grant_valid),
    .grant      (grant)
  );

  // Only the completion kind matching the transaction counts; the other is ignored.
  assign read_done  = (state == ST_WAIT) && !request_type && memory_ready;
  assign write_done = (state == ST_WAIT) &&  request_type && write_complete;
  assign timed_out  = (state == ST_WAIT) && !read_done && !write_done && (wait_cnt == WAIT_LAST);
  assign rdata_load = read_done || timed_out;
  assign rdata_next = timed_out ? 16'h0000 : data_in;

  // Derived from the state register so reset drops them asynchronously.
  assign request = (state == ST_ISSUE);
  assign busy    = (state != ST_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= ST_IDLE;
      wait_cnt        <= '0;
      gap_cnt         <= '0;
      granted         <= PORT_FETCH;
      request_type    <= 1'b0;
      request_address <= '0;
      data_out        <= '0;
      if_rdata        <= '0;
      d_rdata         <= '0;
      if_valid        <= 1'b0;
      d_valid         <= 1'b0;
      timeout_err     <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            granted <= grant;
            state   <= ST_ISSUE;
            if (grant == PORT_DATA) begin
              request_type    <= d_we;
              request_address <= d_addr;
              data_out        <= d_wdata;
            end else begin
              request_type    <= 1'b0;
              request_address <= if_addr;
              data_out        <= 16'h0000;
            end
          end
        end
        ST_ISSUE: begin
          wait_cnt <= '0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (read_done || write_done || timed_out) begin
            state    <= ST_GAP;
            wait_cnt <= '0;
            gap_cnt  <= '0;
            if (timed_out) begin
              timeout_err <= 1'b1;
            end
            if (granted == PORT_DATA) begin
              d_valid <= 1'b1;
              if (rdata_load) begin
                d_rdata <= rdata_next;
              end
            end else begin
              if_valid <= 1'b1;
              if (rdata_load) begin
                if_rdata <= rdata_next;
              end
            end
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            state   <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Directed bench for mem_request_arbiter: a default-parameter instance and a
// TIMEOUT_CYCLES=8 instance share inputs; inputs change on falling edges.
`timescale 1ns/1ps
module tb_mem_request_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [15:0] if_addr = '0, d_addr = '0, d_wdata = '0, data_in = '0;
  logic        memory_ready = 1'b0, write_complete = 1'b0;

  logic [15:0] if_rdata, d_rdata, request_address, data_out;
  logic        if_valid, d_valid, request, request_type, timeout_err, busy;
  logic [15:0] to_if_rdata, to_d_rdata, to_request_address, to_data_out;
  logic        to_if_valid, to_d_valid, to_request, to_request_type, to_timeout_err, to_busy;

  int errors = 0;
  int checks = 0;
  int mon_req = 0, mon_if = 0, mon_d = 0;
  int b_req, b_if, b_d;

  always #5 clk = ~clk;

  mem_request_arbiter dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .request(request), .request_type(request_type),
    .request_address(request_address), .data_out(data_out),
    .data_in(data_in), .memory_ready(memory_ready), .write_complete(write_complete),
    .timeout_err(timeout_err), .busy(busy)
  );

  mem_request_arbiter #(.TIMEOUT_CYCLES(8), .GAP_CYCLES(2)) dut_to (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(to_if_rdata), .if_valid(to_if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(to_d_rdata), .d_valid(to_d_valid),
    .request(to_request), .request_type(to_request_type),
    .request_address(to_request_address), .data_out(to_data_out),
    .data_in(data_in), .memory_ready(memory_ready), .write_complete(write_complete),
    .timeout_err(to_timeout_err), .busy(to_busy)
  );

  // Pulse counters for the default instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (request)  mon_req++;
    if (if_valid) mon_if++;
    if (d_valid)  mon_d++;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_inputs();
    if_req = 0; d_req = 0; d_we = 0; if_addr = '0; d_addr = '0; d_wdata = '0;
    data_in = '0; memory_ready = 0; write_complete = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_inputs();
    step(2);
    reset = 1'b0;
  endtask

  task automatic snap();
    b_req = mon_req; b_if = mon_if; b_d = mon_d;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    step(2);
    checks++; if ({request, request_type, if_valid, d_valid, timeout_err, busy} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 000000", {request, request_type, if_valid, d_valid, timeout_err, busy}); end
    checks++; if ({request_address, data_out, if_rdata, d_rdata} !== 64'h0) begin
      errors++; $display("FAIL reset_data: got %h want 0", {request_address, data_out, if_rdata, d_rdata}); end
    checks++; if (to_busy !== 1'b0) begin errors++; $display("FAIL reset_to_busy: got %b want 0", to_busy); end
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    do_reset();
    snap();
    d_req = 1; d_we = 0; d_addr = 16'h1234;
    step(1);
    checks++; if ({request, request_type, request_address} !== {1'b1, 1'b0, 16'h1234}) begin
      errors++; $display("FAIL rd_issue: got req=%b type=%b addr=%h want 1 0 1234", request, request_type, request_address); end
    step(9);
    checks++; if ({d_valid, request_address, busy} !== {1'b0, 16'h1234, 1'b1}) begin
      errors++; $display("FAIL rd_wait: got valid=%b addr=%h busy=%b want 0 1234 1", d_valid, request_address, busy); end
    memory_ready = 1; data_in = 16'hBEEF;
    step(1);
    memory_ready = 0; d_req = 0;
    checks++; if ({d_valid, d_rdata} !== {1'b1, 16'hBEEF}) begin
      errors++; $display("FAIL rd_done: got valid=%b rdata=%h want 1 beef", d_valid, d_rdata); end
    step(1);
    checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL rd_pulse_width: got %b want 0", d_valid); end
    step(3);
    checks++; if ({mon_req - b_req, mon_d - b_d, mon_if - b_if} !== {32'd1, 32'd1, 32'd0}) begin
      errors++; $display("FAIL rd_counts: got req=%0d d=%0d if=%0d want 1 1 0", mon_req - b_req, mon_d - b_d, mon_if - b_if); end
  endtask

  task automatic test_tie();
    do_reset();
    snap();
    if_req = 1; if_addr = 16'h0010; d_req = 1; d_we = 0; d_addr = 16'h8000;
    step(1);
    checks++; if ({request, request_address} !== {1'b1, 16'h8000}) begin
      errors++; $display("FAIL tie_first: got req=%b addr=%h want 1 8000", request, request_address); end
    step(1);
    memory_ready = 1; data_in = 16'h1111;
    step(1);
    memory_ready = 0; d_req = 0;
    checks++; if ({d_valid, if_valid, d_rdata} !== {1'b1, 1'b0, 16'h1111}) begin
      errors++; $display("FAIL tie_d_done: got d=%b if=%b rdata=%h want 1 0 1111", d_valid, if_valid, d_rdata); end
    step(1);
    checks++; if ({request, busy} !== 2'b01) begin
      errors++; $display("FAIL tie_gap1: got req=%b busy=%b want 0 1", request, busy); end
    step(1);
    checks++; if (request !== 1'b0) begin errors++; $display("FAIL tie_gap2: got req=%b want 0", request); end
    step(1);
    checks++; if ({request, request_address, request_type} !== {1'b1, 16'h0010, 1'b0}) begin
      errors++; $display("FAIL tie_second: got req=%b addr=%h type=%b want 1 0010 0", request, request_address, request_type); end
    step(1);
    memory_ready = 1; data_in = 16'h2222;
    step(1);
    memory_ready = 0; if_req = 0;
    checks++; if ({if_valid, d_valid, if_rdata, d_rdata} !== {1'b1, 1'b0, 16'h2222, 16'h1111}) begin
      errors++; $display("FAIL tie_if_done: got if=%b d=%b if_rdata=%h d_rdata=%h want 1 0 2222 1111", if_valid, d_valid, if_rdata, d_rdata); end
    step(3);
    checks++; if ({mon_req - b_req, mon_d - b_d, mon_if - b_if} !== {32'd2, 32'd1, 32'd1}) begin
      errors++; $display("FAIL tie_counts: got req=%0d d=%0d if=%0d want 2 1 1", mon_req - b_req, mon_d - b_d, mon_if - b_if); end
  endtask

  task automatic test_write();
    do_reset();
    snap();
    d_req = 1; d_we = 1; d_addr = 16'h00FF; d_wdata = 16'hA5A5;
    step(1);
    checks++; if ({request, request_type, request_address, data_out} !== {1'b1, 1'b1, 16'h00FF, 16'hA5A5}) begin
      errors++; $display("FAIL wr_issue: got req=%b type=%b addr=%h dout=%h want 1 1 00ff a5a5", request, request_type, request_address, data_out); end
    step(1);
    memory_ready = 1; data_in = 16'hDEAD;
    step(1);
    memory_ready = 0;
    checks++; if ({d_valid, busy, data_out} !== {1'b0, 1'b1, 16'hA5A5}) begin
      errors++; $display("FAIL wr_stray: got valid=%b busy=%b dout=%h want 0 1 a5a5", d_valid, busy, data_out); end
    step(1);
    checks++; if ({data_out, request_type} !== {16'hA5A5, 1'b1}) begin
      errors++; $display("FAIL wr_hold: got dout=%h type=%b want a5a5 1", data_out, request_type); end
    write_complete = 1;
    step(1);
    write_complete = 0; d_req = 0;
    checks++; if ({d_valid, d_rdata} !== {1'b1, 16'h0000}) begin
      errors++; $display("FAIL wr_done: got valid=%b rdata=%h want 1 0000", d_valid, d_rdata); end
    step(3);
    checks++; if ({mon_req - b_req, mon_d - b_d} !== {32'd1, 32'd1}) begin
      errors++; $display("FAIL wr_counts: got req=%0d d=%0d want 1 1", mon_req - b_req, mon_d - b_d); end
  endtask

  task automatic test_idle_gap_pulses();
    do_reset();
    snap();
    if_req = 1; if_addr = 16'h0042;
    step(2);
    memory_ready = 1; data_in = 16'h4242;
    step(1);
    if_req = 0; data_in = 16'h9999;
    checks++; if ({if_valid, if_rdata} !== {1'b1, 16'h4242}) begin
      errors++; $display("FAIL ig_read: got valid=%b rdata=%h want 1 4242", if_valid, if_rdata); end
    step(1);
    memory_ready = 0;
    checks++; if ({if_valid, if_rdata, busy} !== {1'b0, 16'h4242, 1'b1}) begin
      errors++; $display("FAIL ig_gap: got valid=%b rdata=%h busy=%b want 0 4242 1", if_valid, if_rdata, busy); end
    step(1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ig_back_idle: got busy=%b want 0", busy); end
    memory_ready = 1; write_complete = 1; data_in = 16'h5555;
    step(1);
    memory_ready = 0; write_complete = 0;
    checks++; if ({busy, request, if_valid, d_valid, if_rdata, d_rdata} !== {4'b0000, 16'h4242, 16'h0000}) begin
      errors++; $display("FAIL ig_idle: got busy=%b req=%b if=%b d=%b if_rdata=%h d_rdata=%h want 0 0 0 0 4242 0000",
                         busy, request, if_valid, d_valid, if_rdata, d_rdata); end
    step(2);
    checks++; if ({mon_req - b_req, mon_if - b_if, mon_d - b_d} !== {32'd1, 32'd1, 32'd0}) begin
      errors++; $display("FAIL ig_counts: got req=%0d if=%0d d=%0d want 1 1 0", mon_req - b_req, mon_if - b_if, mon_d - b_d); end
  endtask

  task automatic test_timeout();
    do_reset();
    if_req = 1; if_addr = 16'h0011;
    step(2);
    memory_ready = 1; data_in = 16'h3C3C;
    step(1);
    memory_ready = 0; if_req = 0;
    checks++; if ({to_if_valid, to_if_rdata, to_timeout_err} !== {1'b1, 16'h3C3C, 1'b0}) begin
      errors++; $display("FAIL to_first: got valid=%b rdata=%h err=%b want 1 3c3c 0", to_if_valid, to_if_rdata, to_timeout_err); end
    step(2);
    if_req = 1; if_addr = 16'h0ABC;
    step(9);
    checks++; if ({to_timeout_err, to_if_valid, to_busy} !== 3'b001) begin
      errors++; $display("FAIL to_early: got err=%b valid=%b busy=%b want 0 0 1", to_timeout_err, to_if_valid, to_busy); end
    step(1);
    if_req = 0;
    checks++; if ({to_timeout_err, to_if_valid, to_if_rdata} !== {1'b1, 1'b1, 16'h0000}) begin
      errors++; $display("FAIL to_abort: got err=%b valid=%b rdata=%h want 1 1 0000", to_timeout_err, to_if_valid, to_if_rdata); end
    step(1);
    checks++; if (to_if_valid !== 1'b0) begin errors++; $display("FAIL to_pulse_width: got %b want 0", to_if_valid); end
    step(1);
    d_req = 1; d_we = 0; d_addr = 16'h2222;
    step(2);
    memory_ready = 1; data_in = 16'h6060;
    step(1);
    memory_ready = 0; d_req = 0;
    checks++; if ({to_d_valid, to_d_rdata, to_timeout_err} !== {1'b1, 16'h6060, 1'b1}) begin
      errors++; $display("FAIL to_after: got valid=%b rdata=%h err=%b want 1 6060 1", to_d_valid, to_d_rdata, to_timeout_err); end
    step(3);
    checks++; if (to_timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b want 1", to_timeout_err); end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    snap();
    d_req = 1; d_we = 0; d_addr = 16'h0333;
    step(2);
    checks++; if ({busy, request} !== 2'b10) begin
      errors++; $display("FAIL rm_in_wait: got busy=%b req=%b want 1 0", busy, request); end
    reset = 1'b1;
    #1;
    checks++; if ({request, busy, if_valid, d_valid} !== 4'b0000) begin
      errors++; $display("FAIL rm_async: got req=%b busy=%b if=%b d=%b want 0 0 0 0", request, busy, if_valid, d_valid); end
    step(1);
    reset = 1'b0; d_req = 0; memory_ready = 1; data_in = 16'h0BAD;
    step(1);
    memory_ready = 0;
    checks++; if ({d_valid, d_rdata, busy} !== {1'b0, 16'h0000, 1'b0}) begin
      errors++; $display("FAIL rm_stale: got valid=%b rdata=%h busy=%b want 0 0000 0", d_valid, d_rdata, busy); end
    d_req = 1; d_addr = 16'h0444;
    step(1);
    d_req = 0;
    checks++; if ({request, request_address} !== {1'b1, 16'h0444}) begin
      errors++; $display("FAIL rm_reissue: got req=%b addr=%h want 1 0444", request, request_address); end
    step(1);
    memory_ready = 1; data_in = 16'h4444;
    step(1);
    memory_ready = 0;
    checks++; if ({d_valid, d_rdata} !== {1'b1, 16'h4444}) begin
      errors++; $display("FAIL rm_done: got valid=%b rdata=%h want 1 4444", d_valid, d_rdata); end
    step(3);
    checks++; if ({mon_req - b_req, mon_d - b_d} !== {32'd2, 32'd1}) begin
      errors++; $display("FAIL rm_counts: got req=%0d d=%0d want 2 1", mon_req - b_req, mon_d - b_d); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_tie();
    test_write();
    test_idle_gap_pulses();
    test_timeout();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_request_arbiter.md
MEM_REQUEST_ARBITER -- requirements
Module: mem_request_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: WAIT cycles before a transaction is aborted.
REQ-002 SHALL have parameter GAP_CYCLES, default 2: idle cycles enforced after each completion before the next issue.
REQ-003 SHALL have ports: clk  in  1  clock, rising edge; reset  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: if_req  in  1  fetch request (level); if_addr  in  16  fetch address; if_rdata  out  16  fetch data; if_valid  out  1  fetch done pulse.
REQ-005 SHALL have ports: d_req  in  1  data request (level); d_we  in  1  1 write/0 read; d_addr  in  16; d_wdata  in  16; d_rdata  out  16; d_valid  out  1  data done pulse.
REQ-006 SHALL have ports: request  out  1; request_type  out  1  0 read/1 write; request_address  out  16; data_out  out  16.
REQ-007 SHALL have ports: data_in  in  16; memory_ready  in  1  read done pulse; write_complete  in  1  write done pulse.
REQ-008 SHALL have ports: timeout_err  out  1  sticky abort flag; busy  out  1  high in every state except IDLE.

Function
REQ-009 SHALL implement states IDLE, ISSUE, WAIT, GAP.
REQ-010 IDLE: if any req is high, SHALL grant one requester, register its address, type and wdata (fetch is always a read), and go to ISSUE.
REQ-011 When both requests are high in the same cycle, SHALL grant the port not granted last; last_grant resets to fetch, so data wins the first tie.
REQ-012 ISSUE: SHALL assert request for exactly one cycle with the registered request_type/request_address/data_out, then go to WAIT.
REQ-013 request_type, request_address and data_out SHALL stay stable from ISSUE until WAIT exits.
REQ-014 WAIT, read transaction: memory_ready SHALL capture data_in into the granted port's rdata, pulse that port's valid on the next cycle, and go to GAP.
REQ-015 WAIT, write transaction: write_complete SHALL pulse d_valid on the next cycle and go to GAP; d_rdata is unchanged.
REQ-016 WAIT: a completion pulse of the wrong kind (memory_ready on a write, write_complete on a read) SHALL be ignored.
REQ-017 WAIT: an 8-bit counter SHALL count from 0; on reaching TIMEOUT_CYCLES with no valid completion, the block SHALL set timeout_err, return rdata 16'h0000 with a valid pulse to the granted port, and go to GAP.
REQ-018 GAP: SHALL hold GAP_CYCLES cycles, then return to IDLE; requests arriving in GAP wait.
REQ-019 A completion pulse in IDLE, ISSUE or GAP SHALL be ignored, with no output change.
REQ-020 valid SHALL pulse for exactly one cycle per grant; rdata SHALL hold until the next read completion on that port.
REQ-021 The requester SHALL hold req until its valid pulse and may re-assert on the cycle after.
REQ-022 A requester dropping req after grant SHALL NOT abort the transaction; its valid still pulses.
REQ-023 Minimum latency SHALL be: grant edge -> ISSUE -> WAIT; completion seen in WAIT; valid the following cycle.
REQ-024 timeout_err SHALL clear only on reset.

Reset
REQ-025 On reset the block SHALL enter IDLE and drive request=0, request_type=0, request_address=0, data_out=0, if_rdata=0, d_rdata=0, if_valid=0, d_valid=0, timeout_err=0, busy=0, counters=0, last_grant=fetch.
REQ-026 Reset mid-transaction SHALL drop request immediately and emit no valid pulse.

Structure
REQ-027 State encodings, default TIMEOUT_CYCLES/GAP_CYCLES and the port-select encoding SHALL live in shared package mem_pkg, shared with the memory controller.
REQ-028 Arbitration SHALL be a sub-module rr_arbiter2 (2-input round-robin, registered last_grant); the FSM stays in the top module.

Verification
REQ-029 d_req=1, d_we=0, d_addr=16'h1234; memory_ready with data_in=16'hBEEF 10 cycles later -> exactly one request pulse, request_address=16'h1234, type 0; d_rdata=16'hBEEF and d_valid for one cycle.
REQ-030 if_req and d_req rise together (reads, addresses 16'h0010 and 16'h8000) -> data served first, then fetch after GAP_CYCLES; each valid pulses once, on its own port.
REQ-031 d_we=1, d_addr=16'h00FF, d_wdata=16'hA5A5; stray memory_ready in WAIT, then write_complete -> stray pulse ignored; d_valid once after write_complete; data_out=16'hA5A5 throughout WAIT.
REQ-032 Fetch read with no completion, TIMEOUT_CYCLES=8 -> after 8 WAIT cycles timeout_err=1, if_rdata=16'h0000, one if_valid pulse; timeout_err still 1 after the next successful transaction.
REQ-033 Reset asserted during WAIT -> request, valids and busy go to 0 immediately; a later memory_ready is ignored; a new request after reset is served normally.
REQ-034 Completion pulse injected in IDLE and in GAP -> no valid pulse, no state change.
